// File: rtl/axis_i2c_tx_fifo_if.sv
// Byte-stream handshake bundle shared by the host side and the I2C master side.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_tx_fifo.sv
// Shared stream parameters for the I2C transmit path.
package axis_i2c_pkg;
  localparam int unsigned AXIS_DATA_WIDTH = 8;
endpackage

// First-word-fall-through byte buffer feeding the I2C master's stream input.
module axis_i2c_tx_fifo
  import axis_i2c_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH  = AW + 1
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  axis_if.slave                s_axis,
  axis_if.master               m_axis,
  output logic [CNT_WIDTH-1:0] level_o,
  output logic                 full_o,
  output logic                 empty_o
);

  // DEPTH is a power of two, so it is exactly the pointer wrap bit.
  localparam logic [CNT_WIDTH-1:0] PTR_MSB = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0]  wr_ptr;
  logic [CNT_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  wr_nxt;
  logic [CNT_WIDTH-1:0]  rd_nxt;
  logic                  tready_q;
  logic                  push_c;
  logic                  pop_c;
  logic                  full_nxt;
  logic                  empty_nxt;

  assign push_c = s_axis.tvalid & tready_q;
  assign pop_c  = m_axis.tready & ~empty_o;

  assign s_axis.tready = tready_q;
  assign m_axis.tvalid = ~empty_o;
  assign m_axis.tdata  = mem[rd_ptr[AW-1:0]];

  // Next pointer state and the flags derived from it.
  always_comb begin
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    if (push_c) wr_nxt = wr_ptr + CNT_WIDTH'(1);
    if (pop_c)  rd_nxt = rd_ptr + CNT_WIDTH'(1);
    empty_nxt = (wr_nxt == rd_nxt);
    full_nxt  = (wr_nxt == (rd_nxt ^ PTR_MSB));
  end

  // Pointer, level and flag registers; tready depends only on next-cycle fill.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_o  <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
      tready_q <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      level_o  <= wr_nxt - rd_nxt;
      full_o   <= full_nxt;
      empty_o  <= empty_nxt;
      tready_q <= ~full_nxt;
    end
  end

  // Storage write; never touches the head slot while it is being presented.
  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= s_axis.tdata;
  end

endmodule

// File: tb/tb_axis_i2c_tx_fifo.sv
// Directed and randomised checks of the I2C transmit byte FIFO.
module tb_axis_i2c_tx_fifo;
  localparam int unsigned DW = axis_i2c_pkg::AXIS_DATA_WIDTH;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] level;
  logic       full;
  logic       empty;

  axis_if #(.DATA_WIDTH(DW)) s_if ();
  axis_if #(.DATA_WIDTH(DW)) m_if ();

  axis_i2c_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
    .clk_i   (clk),
    .arstn_i (rst_n),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [DW-1:0] sb [$];
  int          mlevel     = 0;
  logic        exp_tready = 1'b0;
  logic        hold       = 1'b0;
  logic [DW-1:0] held     = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    m_if.tready = 1'b1;
    for (int k = 0; k < 300 && !empty; k++) step();
    m_if.tready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard/model: checks state after each edge, then records the handshakes of the next edge.
  always begin
    logic do_push;
    logic do_pop;
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("level", 32'(level), 32'(mlevel));
      chk("level_max", 32'(level <= 5'd16), 32'd1);
      chk("m_tvalid", 32'(m_if.tvalid), 32'(mlevel != 0));
      chk("s_tready", 32'(s_if.tready), 32'(exp_tready));
      chk("full", 32'(full), 32'(mlevel == 16));
      chk("empty", 32'(empty), 32'(mlevel == 0));
      if (hold) begin
        chk("hold_valid", 32'(m_if.tvalid), 32'd1);
        chk("hold_data", 32'(m_if.tdata), 32'(held));
      end
      do_pop  = m_if.tvalid && m_if.tready;
      do_push = s_if.tvalid && s_if.tready;
      if (do_pop) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) chk("pop_data", 32'(m_if.tdata), 32'(sb.pop_front()));
      end
      hold = m_if.tvalid && !m_if.tready;
      held = m_if.tdata;
      if (do_push) sb.push_back(s_if.tdata);
      mlevel     = mlevel + int'(do_push) - int'(do_pop);
      exp_tready = (mlevel < 16);
    end
  end

  // Reset discards everything in the model too.
  always @(negedge rst_n) begin
    sb.delete();
    mlevel     = 0;
    exp_tready = 1'b0;
    hold       = 1'b0;
  end

  initial begin
    int sent;
    int cyc;
    logic will;

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;

    // Reset held for 5 cycles, then released on a falling edge.
    repeat (5) @(negedge clk);
    chk("rst_tready", 32'(s_if.tready), 32'd0);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready_before_edge", 32'(s_if.tready), 32'd0);
    step();
    chk("rel_tready_after_edge", 32'(s_if.tready), 32'd1);
    chk("rel_level", 32'(level), 32'd0);

    // Single byte through.
    s_if.tdata  = 8'hA5;
    s_if.tvalid = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    chk("one_tvalid", 32'(m_if.tvalid), 32'd1);
    chk("one_tdata", 32'(m_if.tdata), 32'hA5);
    chk("one_level", 32'(level), 32'd1);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    chk("one_empty", 32'(empty), 32'd1);

    // Fill to full, then a held extra byte waits for a slot.
    for (int i = 0; i < 16; i++) begin
      s_if.tdata  = 8'(i);
      s_if.tvalid = 1'b1;
      step();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_tready", 32'(s_if.tready), 32'd0);
    s_if.tdata = 8'hFF;
    repeat (3) step();
    chk("held_level", 32'(level), 32'd16);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    chk("slot_level", 32'(level), 32'd15);
    chk("slot_tready", 32'(s_if.tready), 32'd1);
    step();
    s_if.tvalid = 1'b0;
    chk("refill_level", 32'(level), 32'd16);
    chk("refill_full", 32'(full), 32'd1);
    drain();

    // Random streaming with random source gaps and sink backpressure.
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 5000) begin
      if (!s_if.tvalid && $urandom_range(0, 3) != 0) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'($urandom);
      end
      m_if.tready = 1'($urandom_range(0, 1));
      will = s_if.tvalid && s_if.tready;
      step();
      if (will) begin
        sent++;
        s_if.tvalid = 1'b0;
      end
      cyc++;
    end
    s_if.tvalid = 1'b0;
    chk("rand_sent", 32'(sent), 32'd200);
    drain();

    // Concurrent push and pop at level 5 across the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      s_if.tdata  = 8'(8'h50 + i);
      s_if.tvalid = 1'b1;
      step();
    end
    m_if.tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_if.tdata = 8'(8'h60 + i);
      step();
      chk("pp_level", 32'(level), 32'd5);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    drain();

    // Asynchronous reset at level 9 with the burst still running.
    for (int i = 0; i < 9; i++) begin
      s_if.tdata  = 8'(8'h90 + i);
      s_if.tvalid = 1'b1;
      step();
    end
    chk("pre_rst_level", 32'(level), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("arst_tready", 32'(s_if.tready), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    s_if.tdata  = 8'h3C;
    s_if.tvalid = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    chk("post_rst_tdata", 32'(m_if.tdata), 32'h3C);
    chk("post_rst_level", 32'(level), 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_i2c_tx_fifo.md
Name: axis_i2c_tx_fifo

Overview:
Byte-stream buffer between the host-side AXI-Stream source and the I2C master's AXIS slave port. It absorbs bursts of write-data or command bytes while the I2C engine is clocking bits out slowly on the bus. It is a synchronous, first-word-fall-through FIFO with an axis_if slave modport on the input and an axis_if master modport on the output. It also reports a fill level for status registers.

Parameters:
DATA_WIDTH, AXIS_DATA_WIDTH (axis_i2c_pkg), width of tdata on both sides
DEPTH, 16, number of entries; power of two, minimum 2
CNT_WIDTH, $clog2(DEPTH)+1, width of the fill-level output (derived, not overridden)

Ports:
clk_i  input  1  single clock; all logic rising-edge
arstn_i  input  1  asynchronous active-low reset
s_axis  slave modport  axis_if.slave  upstream stream in: tdata[DATA_WIDTH], tvalid in; tready out
m_axis  master modport  axis_if.master  downstream stream out to I2C master: tdata[DATA_WIDTH], tvalid out; tready in
level_o  output  CNT_WIDTH  current number of stored entries, 0..DEPTH
full_o  output  1  level_o == DEPTH
empty_o  output  1  level_o == 0

Behaviour:
- Reset (arstn_i low, async assert, release sampled on clk_i):
  - wr_ptr = rd_ptr = 0; level_o = 0.
  - s_axis.tready = 0; m_axis.tvalid = 0.
  - empty_o = 1; full_o = 0.
  - Memory contents are don't-care.
- Pointers are CNT_WIDTH wide:
  - index = low $clog2(DEPTH) bits.
  - MSB distinguishes full from empty.
  - Both wrap naturally from DEPTH*2-1 to 0.
- s_axis.tready is a register. It is 1 from the first clk_i edge after reset release whenever the next-cycle level is < DEPTH. No combinational path from m_axis.tready to s_axis.tready.
- Push = s_axis.tvalid & s_axis.tready. On push, tdata is written to mem[wr_ptr] and wr_ptr increments.
- Pop = m_axis.tvalid & m_axis.tready. On pop, rd_ptr increments.
- FWFT read path:
  - m_axis.tdata = mem[rd_ptr index].
  - m_axis.tvalid = !empty. Both are combinational from registered state.
- Latency: a byte pushed at edge N has m_axis.tvalid high after edge N (one-cycle write-to-read latency). No same-cycle pass-through when empty.
- Level update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop
- Simultaneous push and pop:
  - Allowed whenever tready is high and the FIFO is non-empty; level is unchanged.
  - When full, tready is already 0, so a pop frees one slot and tready rises after that edge.
- Full: s_axis.tready = 0; upstream must hold tdata/tvalid stable (AXIS rule). No data is lost or overwritten.
- Empty: m_axis.tvalid = 0; m_axis.tdata is don't-care; a pop cannot occur.
- AXIS compliance on the output: once tvalid is high, tvalid and tdata stay stable until the pop. This holds because pushes never modify mem[rd_ptr] while the FIFO is non-empty.
- Reset mid-operation:
  - All stored data is discarded; outputs immediately go to their reset values (asynchronous).
  - A partially accepted burst is not resumed.
- full_o, empty_o and level_o are consistent with the pointer state after every edge.

Test Plan:
- Reset release: hold arstn_i low 5 cycles then release -> tready 0 during reset, 1 on the first edge after; tvalid 0; level_o 0; empty_o 1.
- Single byte: push 0xA5 at edge N with m_axis.tready low -> tvalid 1 and tdata 0xA5 after edge N, level_o 1; assert tready -> popped at next edge, empty_o 1.
- Fill to full: push 0x00..0x0F back-to-back (DEPTH 16) with m_axis.tready 0 -> full_o 1, level_o 16, s_axis.tready 0; an extra held byte 0xFF is not accepted until one pop occurs, then it is accepted, and the drain order is 0x00..0x0F, 0xFF.
- Streaming with random backpressure: 200 random bytes, random tvalid and random m_axis.tready -> output sequence is identical to the input; tdata stable while tvalid && !tready; level_o never exceeds 16.
- Simultaneous push/pop at level 5 for 40 cycles -> level_o stays 5; pointers wrap past index 15 without corruption.
- Async reset at level 9 mid-burst -> level_o 0, tvalid 0 immediately without a clock edge; the next pushed byte 0x3C is the first one output.
